dcache_ctrl: RTL and testbench

- Direct-mapped, write-back, write-allocate data cache between the pipelined MIPS core's MEM stage and the block-organised data memory.
- Consumes the core's word requests (data_address_2DM, MemRead, MemWrite, data_write_2DM).
- Returns read data and a stall.
- Exchanges 256-bit lines with data memory via dBlkRead/dBlkWrite.

---
 rtl/dcache_ctrl_if.sv | 26 ++
 rtl/dcache_ctrl.sv | 124 ++++++++++++
 tb/tb_dcache_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_ctrl_if.sv
// Core-side and memory-side signal bundle for the data cache controller.
// The cache takes the slave view; the core/memory side takes the master view.
interface dcache_ctrl_if;
    logic [31:0]  cpu_addr;
    logic         cpu_read;
    logic         cpu_write;
    logic [31:0]  cpu_wdata;
    logic [31:0]  cpu_rdata;
    logic         cpu_stall;
    logic [31:0]  mem_addr;
    logic         dBlkRead;
    logic         dBlkWrite;
    logic [255:0] block_write_2DM;
    logic [255:0] block_read_fDM;
    logic         mem_ack;

    modport slave (
        input  cpu_addr, cpu_read, cpu_write, cpu_wdata, block_read_fDM, mem_ack,
        output cpu_rdata, cpu_stall, mem_addr, dBlkRead, dBlkWrite, block_write_2DM
    );

    modport master (
        output cpu_addr, cpu_read, cpu_write, cpu_wdata, block_read_fDM, mem_ack,
        input  cpu_rdata, cpu_stall, mem_addr, dBlkRead, dBlkWrite, block_write_2DM
    );
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache between the MEM stage
// and a block-organised data memory. Lines are 8 words (256 bits).
module dcache_ctrl #(
    parameter int LINES = 16
) (
    input logic          CLK,
    input logic          RESET,
    dcache_ctrl_if.slave bus
);
    localparam int INDEX_W        = $clog2(LINES);
    localparam int TAG_W          = 27 - INDEX_W;
    localparam int WORDS_PER_LINE = 8;
    localparam int LINE_W         = 32 * WORDS_PER_LINE;

    typedef enum logic [1:0] {IDLE, WRITEBACK, FILL} state_t;

    state_t                 state;
    logic [LINES-1:0]       valid;
    logic [LINES-1:0]       dirty;
    logic [TAG_W-1:0]       tag_mem  [LINES];
    logic [LINE_W-1:0]      data_mem [LINES];

    logic [2:0]             offset;
    logic [INDEX_W-1:0]     index;
    logic [TAG_W-1:0]       tag;
    logic                   req;
    logic                   hit;
    logic                   is_read;
    logic [LINE_W-1:0]      line;
    logic [1:0]             unused_addr;

    assign offset      = bus.cpu_addr[4:2];
    assign index       = bus.cpu_addr[4+INDEX_W:5];
    assign tag         = bus.cpu_addr[31:5+INDEX_W];
    assign unused_addr = bus.cpu_addr[1:0];
    assign req         = bus.cpu_read | bus.cpu_write;
    assign hit         = valid[index] && (tag_mem[index] == tag);
    // A simultaneous read and write is treated as a write.
    assign is_read     = bus.cpu_read & ~bus.cpu_write;
    assign line        = data_mem[index];

    // Stall and read data respond in the same cycle as the request; both are
    // forced low while reset is asserted even if the core holds a request.
    always_comb begin
        bus.cpu_stall = 1'b0;
        bus.cpu_rdata = '0;
        if (RESET) begin
            if (state != IDLE) begin
                bus.cpu_stall = 1'b1;
            end else if (req && !hit) begin
                bus.cpu_stall = 1'b1;
            end else if (is_read && hit) begin
                bus.cpu_rdata = line[{offset, 5'b0} +: 32];
            end
        end
    end

    // Miss handling FSM: line status bits and all memory-side outputs are
    // registered here, so mem_addr/block_write_2DM hold for a whole transfer.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state               <= IDLE;
            valid               <= '0;
            dirty               <= '0;
            bus.mem_addr        <= '0;
            bus.dBlkRead        <= 1'b0;
            bus.dBlkWrite       <= 1'b0;
            bus.block_write_2DM <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        if (hit) begin
                            if (bus.cpu_write) begin
                                dirty[index] <= 1'b1;
                            end
                        end else if (valid[index] && dirty[index]) begin
                            state               <= WRITEBACK;
                            bus.dBlkWrite       <= 1'b1;
                            bus.mem_addr        <= {tag_mem[index], index, 5'b0};
                            bus.block_write_2DM <= line;
                        end else begin
                            state        <= FILL;
                            bus.dBlkRead <= 1'b1;
                            bus.mem_addr <= {tag, index, 5'b0};
                        end
                    end
                end
                WRITEBACK: begin
                    if (bus.mem_ack) begin
                        // Victim is now in memory; the line is invalid until refilled.
                        state         <= FILL;
                        bus.dBlkWrite <= 1'b0;
                        bus.dBlkRead  <= 1'b1;
                        bus.mem_addr  <= {tag, index, 5'b0};
                        valid[index]  <= 1'b0;
                        dirty[index]  <= 1'b0;
                    end
                end
                FILL: begin
                    if (bus.mem_ack) begin
                        state        <= IDLE;
                        bus.dBlkRead <= 1'b0;
                        valid[index] <= 1'b1;
                        dirty[index] <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Tag and data arrays: refill on fill completion, word merge on write hit.
    always_ff @(posedge CLK) begin
        if (state == FILL && bus.mem_ack) begin
            data_mem[index] <= bus.block_read_fDM;
            tag_mem[index]  <= tag;
        end else if (state == IDLE && bus.cpu_write && hit) begin
            data_mem[index][{offset, 5'b0} +: 32] <= bus.cpu_wdata;
        end
    end
endmodule

// File: tb/tb_dcache_ctrl.sv
// Bench for dcache_ctrl: directed scenarios plus randomized traffic, checked
// every cycle against a line-level cache model and a block-level memory model.
module tb_dcache_ctrl;
    localparam int LINES = 16;

    logic CLK;
    logic RESET;

    dcache_ctrl_if bus ();

    dcache_ctrl #(.LINES(LINES)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_chk  = 0;
    int n_fail = 0;

    // Expected outputs for the current cycle.
    logic         chk_en = 1'b0;
    logic         e_stall, e_rd, e_wr, e_chkrd;
    logic [31:0]  e_addr, e_rdata;
    logic [255:0] e_blk;

    // Model: per line, which block it holds and its contents; backing memory by block.
    logic         mvalid [LINES];
    logic         mdirty [LINES];
    logic [31:0]  mbase  [LINES];
    logic [255:0] mdata  [LINES];
    logic [255:0] bmem   [logic [31:0]];

    task automatic check_b(input string nm, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic check_w(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_l(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_i(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [255:0] blk_init(input logic [31:0] base);
        logic [255:0] b;
        for (int k = 0; k < 8; k++) begin
            b[k*32 +: 32] = (base * 32'h9E37_79B1) ^ (32'(k) * 32'h0100_0193) ^ 32'h5A5A_0000;
        end
        return b;
    endfunction

    function automatic logic [255:0] bget(input logic [31:0] base);
        if (bmem.exists(base)) return bmem[base];
        return blk_init(base);
    endfunction

    task automatic set_exp(input logic st, input logic rd, input logic wr, input logic [31:0] ad,
                           input logic [255:0] blk, input logic crd, input logic [31:0] rdt);
        e_stall = st;
        e_rd    = rd;
        e_wr    = wr;
        e_addr  = ad;
        e_blk   = blk;
        e_chkrd = crd;
        e_rdata = rdt;
    endtask

    // Single per-cycle compare process.
    always @(negedge CLK) begin
        if (chk_en) begin
            check_b("cpu_stall", bus.cpu_stall, e_stall);
            check_b("dBlkRead", bus.dBlkRead, e_rd);
            check_b("dBlkWrite", bus.dBlkWrite, e_wr);
            if (e_rd || e_wr) check_w("mem_addr", bus.mem_addr, e_addr);
            if (e_wr) check_l("block_write_2DM", bus.block_write_2DM, e_blk);
            if (e_chkrd) check_w("cpu_rdata", bus.cpu_rdata, e_rdata);
        end
    end

    // Advance one cycle, capturing what the DUT showed at the mid-cycle sample.
    task automatic cyc(output logic st, output logic [31:0] rdt, output logic [255:0] bw);
        @(negedge CLK);
        st  = bus.cpu_stall;
        rdt = bus.cpu_rdata;
        bw  = bus.block_write_2DM;
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n, input logic spurious);
        logic st;
        logic [31:0] r;
        logic [255:0] b;
        bus.cpu_read  = 1'b0;
        bus.cpu_write = 1'b0;
        for (int i = 0; i < n; i++) begin
            set_exp(1'b0, 1'b0, 1'b0, 32'h0, '0, 1'b1, 32'h0);
            bus.mem_ack = spurious ? 1'($urandom_range(0, 1)) : 1'b0;
            cyc(st, r, b);
        end
        bus.mem_ack = 1'b0;
    endtask

    // One core request held until served; memory acks after dwb/dfl wait cycles.
    task automatic do_req(input logic [31:0] a, input logic rd, input logic wr, input logic [31:0] wd,
                          input int dwb, input int dfl,
                          output int nst, output logic [31:0] rdv, output logic [255:0] wbv);
        int idx, off;
        logic [31:0] base, vbase;
        logic hit, wb, st;
        logic [255:0] fblk, b;
        logic [31:0] r;
        base  = a & 32'hFFFF_FFE0;
        idx   = int'((a >> 5) % LINES);
        off   = int'(a[4:2]);
        hit   = mvalid[idx] && (mbase[idx] == base);
        wb    = !hit && mvalid[idx] && mdirty[idx];
        vbase = mbase[idx];
        nst   = 0;
        rdv   = '0;
        wbv   = '0;
        bus.cpu_addr  = a;
        bus.cpu_read  = rd;
        bus.cpu_write = wr;
        bus.cpu_wdata = wd;
        bus.mem_ack   = 1'b0;
        if (!hit) begin
            set_exp(1'b1, 1'b0, 1'b0, 32'h0, '0, 1'b0, 32'h0);
            cyc(st, r, b);
            if (st) nst++;
            if (wb) begin
                for (int i = 0; i <= dwb; i++) begin
                    set_exp(1'b1, 1'b0, 1'b1, vbase, mdata[idx], 1'b0, 32'h0);
                    bus.mem_ack = (i == dwb);
                    cyc(st, r, b);
                    if (st) nst++;
                    wbv = b;
                end
                bmem[vbase] = mdata[idx];
                mvalid[idx] = 1'b0;
                mdirty[idx] = 1'b0;
            end
            fblk = bget(base);
            for (int i = 0; i <= dfl; i++) begin
                set_exp(1'b1, 1'b1, 1'b0, base, '0, 1'b0, 32'h0);
                bus.mem_ack = (i == dfl);
                bus.block_read_fDM = (i == dfl) ? fblk :
                    {$urandom(), $urandom(), $urandom(), $urandom(),
                     $urandom(), $urandom(), $urandom(), $urandom()};
                cyc(st, r, b);
                if (st) nst++;
            end
            bus.mem_ack = 1'b0;
            mvalid[idx] = 1'b1;
            mbase[idx]  = base;
            mdata[idx]  = fblk;
            mdirty[idx] = 1'b0;
        end
        set_exp(1'b0, 1'b0, 1'b0, 32'h0, '0, rd && !wr, mdata[idx][off*32 +: 32]);
        cyc(st, r, b);
        if (st) nst++;
        rdv = r;
        if (wr) begin
            mdata[idx][off*32 +: 32] = wd;
            mdirty[idx] = 1'b1;
        end
        bus.cpu_read  = 1'b0;
        bus.cpu_write = 1'b0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < LINES; i++) begin
            mvalid[i] = 1'b0;
            mdirty[i] = 1'b0;
            mbase[i]  = 32'h0;
            mdata[i]  = '0;
        end
    endtask

    initial begin
        int nst;
        logic [31:0] rdv, a;
        logic [255:0] wbv, b0;
        int kind;

        model_reset();
        set_exp(1'b0, 1'b0, 1'b0, 32'h0, '0, 1'b0, 32'h0);
        bus.cpu_addr       = 32'h0;
        bus.cpu_read       = 1'b0;
        bus.cpu_write      = 1'b0;
        bus.cpu_wdata      = 32'h0;
        bus.mem_ack        = 1'b0;
        bus.block_read_fDM = '0;
        RESET = 1'b1;
        #1 RESET = 1'b0;
        #1;
        check_w("reset cpu_rdata", bus.cpu_rdata, 32'h0);
        check_b("reset cpu_stall", bus.cpu_stall, 1'b0);
        check_w("reset mem_addr", bus.mem_addr, 32'h0);
        check_b("reset dBlkRead", bus.dBlkRead, 1'b0);
        check_b("reset dBlkWrite", bus.dBlkWrite, 1'b0);
        check_l("reset block_write_2DM", bus.block_write_2DM, '0);
        @(posedge CLK);
        #1 RESET = 1'b1;
        chk_en = 1'b1;
        idle(2, 1'b0);

        // Clean read miss, then hit in the same line.
        b0 = blk_init(32'h40);
        b0[95:64] = 32'hDEAD_BEEF;
        bmem[32'h40] = b0;
        do_req(32'h40, 1'b1, 1'b0, 32'h0, 0, 0, nst, rdv, wbv);
        check_i("clean miss stall cycles", nst, 2);
        do_req(32'h48, 1'b1, 1'b0, 32'h0, 0, 0, nst, rdv, wbv);
        check_i("hit stall cycles", nst, 0);
        check_w("read 0x48", rdv, 32'hDEAD_BEEF);

        // Write hit, read back.
        do_req(32'h44, 1'b0, 1'b1, 32'h1234_5678, 0, 0, nst, rdv, wbv);
        check_i("write hit stall cycles", nst, 0);
        do_req(32'h44, 1'b1, 1'b0, 32'h0, 0, 0, nst, rdv, wbv);
        check_w("read 0x44", rdv, 32'h1234_5678);

        // Conflict with the dirty line: writeback then fill.
        do_req(32'h240, 1'b1, 1'b0, 32'h0, 0, 0, nst, rdv, wbv);
        check_i("dirty miss stall cycles", nst, 3);
        check_w("writeback word1", wbv[63:32], 32'h1234_5678);
        check_w("writeback word2", wbv[95:64], 32'hDEAD_BEEF);

        // Clean miss with a slow memory.
        idle(1, 1'b1);
        do_req(32'h40, 1'b1, 1'b0, 32'h0, 0, 5, nst, rdv, wbv);
        check_i("slow fill stall cycles", nst, 7);
        do_req(32'h48, 1'b1, 1'b0, 32'h0, 0, 0, nst, rdv, wbv);
        check_w("refetched 0x48", rdv, 32'hDEAD_BEEF);
        do_req(32'h44, 1'b1, 1'b0, 32'h0, 0, 0, nst, rdv, wbv);
        check_w("refetched 0x44", rdv, 32'h1234_5678);

        // Write miss allocates, merges, and later writes back.
        do_req(32'h64, 1'b0, 1'b1, 32'hCAFE_F00D, 0, 0, nst, rdv, wbv);
        check_i("write miss stall cycles", nst, 2);
        do_req(32'h64, 1'b1, 1'b0, 32'h0, 0, 0, nst, rdv, wbv);
        check_w("read 0x64", rdv, 32'hCAFE_F00D);
        do_req(32'h264, 1'b1, 1'b0, 32'h0, 0, 0, nst, rdv, wbv);
        check_i("evict write-allocated line stalls", nst, 3);
        check_w("evicted word1", wbv[63:32], 32'hCAFE_F00D);

        // Reset in the middle of a fill.
        chk_en = 1'b0;
        bus.cpu_addr = 32'h440;
        bus.cpu_read = 1'b1;
        @(posedge CLK);
        #1;
        check_b("fill dBlkRead", bus.dBlkRead, 1'b1);
        check_b("fill cpu_stall", bus.cpu_stall, 1'b1);
        check_w("fill mem_addr", bus.mem_addr, 32'h440);
        #2 RESET = 1'b0;
        #1;
        check_b("async reset dBlkRead", bus.dBlkRead, 1'b0);
        check_b("async reset cpu_stall", bus.cpu_stall, 1'b0);
        check_w("async reset mem_addr", bus.mem_addr, 32'h0);
        bus.cpu_read = 1'b0;
        @(posedge CLK);
        #1 RESET = 1'b1;
        model_reset();
        chk_en = 1'b1;
        idle(3, 1'b1);
        do_req(32'h40, 1'b1, 1'b0, 32'h0, 0, 0, nst, rdv, wbv);
        check_i("miss after reset stalls", nst, 2);
        check_w("read 0x40 after reset", rdv, bget(32'h40) & 32'hFFFF_FFFF);

        // Randomized traffic over a few conflicting tags.
        for (int it = 0; it < 400; it++) begin
            a = (32'($urandom_range(0, 3)) << 9) | (32'($urandom_range(0, 15)) << 5) |
                (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
            kind = int'($urandom_range(0, 3));
            do_req(a, (kind == 0) || (kind == 2) || (kind == 3), (kind == 1) || (kind == 2),
                   $urandom(), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   nst, rdv, wbv);
            idle(int'($urandom_range(0, 2)), 1'b1);
        end

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
